// File: rtl/accumulator_sequencer.sv
// Address/mask sequencer that steers the skewed MAC-array output into the accumulator RAM.
// Walks T = v_dim + MUL_SIZE - 1 steps per reduction tile with a one-step read look-ahead.
module accumulator_sequencer #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DIM_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                accumulate_i,
    input  logic [DIM_W-1:0]    v_dim_i,
    input  logic [DIM_W-1:0]    u_dim_i,
    input  logic                col_valid_i,
    output logic                busy_o,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [MUL_SIZE-1:0] wr_mask_o,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [MUL_SIZE-1:0] rd_mask_o,
    output logic                acc_add_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    v_q, v_d;
    logic [DIM_W-1:0]    nt_q, nt_d;
    logic                acc_q, acc_d;
    logic [ADDR_W-1:0]   t_q, t_d;
    logic [DIM_W-1:0]    tile_q, tile_d;

    logic                busy_d, wr_en_d, rd_en_d, acc_add_d, done_d, err_d;
    logic [ADDR_W-1:0]   wr_addr_d, rd_addr_d;
    logic [MUL_SIZE-1:0] wr_mask_d, rd_mask_d;

    logic                start_legal;
    logic                last_step;
    logic                last_tile;
    logic                tile_adds;
    logic [ADDR_W-1:0]   t_next;

    // Lane l is live at step t when l <= t and t - l < v; lane 0 lands in the MSB.
    function automatic logic [MUL_SIZE-1:0] lane_mask(input logic [ADDR_W-1:0] t,
                                                      input logic [DIM_W-1:0]  v);
        logic [MUL_SIZE-1:0] m;
        int unsigned         ti;
        int unsigned         vi;
        m  = '0;
        ti = 32'(t);
        vi = 32'(v);
        for (int unsigned l = 0; l < MUL_SIZE; l++) begin
            m = (m << 1) | MUL_SIZE'((l <= ti) && ((ti - l) < vi));
        end
        return m;
    endfunction

    assign start_legal = (v_dim_i != '0) && (u_dim_i != '0) &&
                         ((32'(u_dim_i) % MUL_SIZE) == 32'd0) &&
                         ((32'(v_dim_i) + MUL_SIZE - 32'd1) <= (32'd1 << ADDR_W));
    assign last_step   = (32'(t_q) == (32'(v_q) + MUL_SIZE - 32'd2));
    assign last_tile   = (tile_q == (nt_q - DIM_W'(1)));
    assign tile_adds   = (tile_q != '0) | acc_q;
    assign t_next      = t_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        nt_d      = nt_q;
        acc_d     = acc_q;
        t_d       = t_q;
        tile_d    = tile_q;
        busy_d    = busy_o;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_o;
        wr_mask_d = wr_mask_o;
        rd_en_d   = rd_en_o;
        rd_addr_d = rd_addr_o;
        rd_mask_d = rd_mask_o;
        acc_add_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d    = 1'b0;
                wr_addr_d = '0;
                wr_mask_d = '0;
                rd_en_d   = 1'b0;
                rd_addr_d = '0;
                rd_mask_d = '0;
                if (start_i) begin
                    if (!start_legal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = StArm;
                        v_d       = v_dim_i;
                        nt_d      = DIM_W'(32'(u_dim_i) / MUL_SIZE);
                        acc_d     = accumulate_i;
                        t_d       = '0;
                        tile_d    = '0;
                        busy_d    = 1'b1;
                        rd_en_d   = accumulate_i;
                        rd_mask_d = accumulate_i ? lane_mask('0, v_dim_i) : '0;
                    end
                end
            end
            StArm, StRun: begin
                if (col_valid_i) begin
                    state_d   = StRun;
                    wr_en_d   = 1'b1;
                    wr_addr_d = t_q;
                    wr_mask_d = lane_mask(t_q, v_q);
                    acc_add_d = tile_adds;
                    if (!last_step) begin
                        t_d       = t_next;
                        rd_en_d   = tile_adds;
                        rd_addr_d = tile_adds ? t_next : '0;
                        rd_mask_d = tile_adds ? lane_mask(t_next, v_q) : '0;
                    end else if (!last_tile) begin
                        // Later tiles always read-modify-write, so step 0 is preloaded.
                        t_d       = '0;
                        tile_d    = tile_q + DIM_W'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                        rd_mask_d = lane_mask('0, v_q);
                    end else begin
                        state_d   = StDone;
                        t_d       = '0;
                        tile_d    = '0;
                        busy_d    = 1'b0;
                        rd_en_d   = 1'b0;
                        rd_addr_d = '0;
                        rd_mask_d = '0;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                wr_addr_d = '0;
                wr_mask_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            v_q       <= '0;
            nt_q      <= '0;
            acc_q     <= 1'b0;
            t_q       <= '0;
            tile_q    <= '0;
            busy_o    <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_mask_o <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_mask_o <= '0;
            acc_add_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            nt_q      <= nt_d;
            acc_q     <= acc_d;
            t_q       <= t_d;
            tile_q    <= tile_d;
            busy_o    <= busy_d;
            wr_en_o   <= wr_en_d;
            wr_addr_o <= wr_addr_d;
            wr_mask_o <= wr_mask_d;
            rd_en_o   <= rd_en_d;
            rd_addr_o <= rd_addr_d;
            rd_mask_o <= rd_mask_d;
            acc_add_o <= acc_add_d;
            done_o    <= done_d;
            err_o     <= err_d;
        end
    end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Randomised bench for accumulator_sequencer: a job-level model expands each job into its
// ordered list of writes and compares every registered output cycle by cycle.
module tb_accumulator_sequencer;

    localparam int MS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       acc = 1'b0;
    logic [7:0] v = '0;
    logic [7:0] u = '0;
    logic       cv = 1'b0;

    logic       busy, wr_en, rd_en, acc_add, done, err;
    logic [9:0] wr_addr, rd_addr;
    logic [3:0] wr_mask, rd_mask;

    logic       busy2, wr_en2, rd_en2, acc_add2, done2, err2;
    logic [7:0] wr_addr2, rd_addr2;
    logic [3:0] wr_mask2, rd_mask2;

    int checks = 0;
    int errors = 0;

    int q_addr[$];
    int q_mask[$];
    int q_add[$];

    accumulator_sequencer #(.MUL_SIZE(4), .ADDR_W(10), .DIM_W(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .accumulate_i(acc),
        .v_dim_i(v), .u_dim_i(u), .col_valid_i(cv), .busy_o(busy),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_mask_o(wr_mask),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_mask_o(rd_mask),
        .acc_add_o(acc_add), .done_o(done), .err_o(err)
    );

    // Narrow address space so the T > 2**ADDR_W boundary is reachable with 8-bit dims.
    accumulator_sequencer #(.MUL_SIZE(4), .ADDR_W(8), .DIM_W(8)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start2), .accumulate_i(acc),
        .v_dim_i(v), .u_dim_i(u), .col_valid_i(cv), .busy_o(busy2),
        .wr_en_o(wr_en2), .wr_addr_o(wr_addr2), .wr_mask_o(wr_mask2),
        .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .rd_mask_o(rd_mask2),
        .acc_add_o(acc_add2), .done_o(done2), .err_o(err2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_mask"}, wr_mask, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_mask"}, rd_mask, 0);
        chk({tag, "_acc_add"}, acc_add, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Expand a job into the ordered list of writes it must produce.
    task automatic build_model(input int v_in, input int u_in, input bit acc_in);
        int steps;
        int msk;
        q_addr.delete();
        q_mask.delete();
        q_add.delete();
        steps = v_in + MS - 1;
        for (int k = 0; k < u_in / MS; k++) begin
            for (int t = 0; t < steps; t++) begin
                msk = 0;
                for (int l = 0; l < MS; l++) begin
                    if (l <= t && t - l < v_in) msk |= 1 << (MS - 1 - l);
                end
                q_addr.push_back(t);
                q_mask.push_back(msk);
                q_add.push_back((k > 0 || acc_in) ? 1 : 0);
            end
        end
    endtask

    task automatic run_job(input int v_in, input int u_in, input bit acc_in,
                           input int stall_pct, input bit hold_start, input int abort_at);
        int n;
        int idx;
        int budget;
        int last_addr;
        int last_mask;
        bit prev_cv;
        build_model(v_in, u_in, acc_in);
        n = q_addr.size();
        idx = 0;
        last_addr = 0;
        last_mask = 0;
        prev_cv = 1'b0;
        budget = n * 20 + 50;
        start = 1'b1;
        v = 8'(v_in);
        u = 8'(u_in);
        acc = acc_in;
        cv = 1'b0;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        while (1) begin
            chk("wr_en", wr_en, prev_cv);
            if (wr_en && idx < n) begin
                chk("wr_addr", wr_addr, q_addr[idx]);
                chk("wr_mask", wr_mask, q_mask[idx]);
                chk("acc_add", acc_add, q_add[idx]);
                last_addr = q_addr[idx];
                last_mask = q_mask[idx];
                idx++;
            end else begin
                chk("hold_wr_addr", wr_addr, last_addr);
                chk("hold_wr_mask", wr_mask, last_mask);
                chk("stall_acc_add", acc_add, 0);
            end
            chk("busy", busy, idx < n);
            chk("done_early", done, 0);
            if (idx < n && q_add[idx] == 1) begin
                chk("rd_en", rd_en, 1);
                chk("rd_addr", rd_addr, q_addr[idx]);
                chk("rd_mask", rd_mask, q_mask[idx]);
            end else begin
                chk("rd_en_off", rd_en, 0);
                chk("rd_addr_off", rd_addr, 0);
                chk("rd_mask_off", rd_mask, 0);
            end
            if (idx == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                cv = 1'b1;
                @(negedge clk);
                chk_all_zero("abort");
                rst_n = 1'b1;
                cv = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    chk("abort_no_busy", busy, 0);
                end
                return;
            end
            if (idx >= n) break;
            budget--;
            if (budget == 0) begin
                chk("job_timeout", idx, n);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            cv = ($urandom_range(99) >= stall_pct);
            prev_cv = cv;
            @(negedge clk);
        end
        // DONE cycle: col_valid must be ignored and done_o follows one cycle later.
        start = 1'b0;
        cv = 1'($urandom_range(1));
        @(negedge clk);
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_wr_en", wr_en, 0);
        chk("done_rd_en", rd_en, 0);
        cv = 1'b0;
    endtask

    task automatic run_err(input int v_in, input int u_in, input bit on_dut2);
        v = 8'(v_in);
        u = 8'(u_in);
        if (on_dut2) start2 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        if (on_dut2) begin
            chk("err2", err2, 1);
            chk("err2_busy", busy2, 0);
        end else begin
            chk("err", err, 1);
            chk("err_busy", busy, 0);
            chk("err_wr_en", wr_en, 0);
        end
        @(negedge clk);
        chk("err_pulse", on_dut2 ? err2 : err, 0);
        chk("err_busy_after", on_dut2 ? busy2 : busy, 0);
    endtask

    initial begin
        int rv;
        int ru;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(3, 8, 1'b0, 0, 1'b0, -1);
        run_job(6, 4, 1'b1, 0, 1'b0, -1);
        run_job(3, 8, 1'b0, 40, 1'b0, -1);

        run_err(3, 6, 1'b0);
        run_err(0, 8, 1'b0);
        run_err(3, 0, 1'b0);

        run_job(3, 8, 1'b0, 0, 1'b0, 10);
        run_job(3, 8, 1'b0, 0, 1'b0, -1);

        run_job(3, 8, 1'b0, 20, 1'b1, -1);
        run_job(5, 8, 1'b1, 0, 1'b0, -1);

        for (int j = 0; j < 8; j++) begin
            rv = int'($urandom_range(12, 1));
            ru = MS * int'($urandom_range(3, 1));
            run_job(rv, ru, 1'($urandom_range(1)), int'($urandom_range(50)), 1'b0, -1);
        end

        // Narrow instance: v=254 gives T=257 > 256, v=253 gives T=256 and is accepted.
        run_err(254, 4, 1'b1);
        v = 8'd253;
        u = 8'd4;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("t_max_legal_err", err2, 0);
        chk("t_max_legal_busy", busy2, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
